// File: rtl/etc_tile_sched.sv
// Job scheduler for the extended tensor core: streams K operand tile pairs into
// the core, tracks its two-cycle result latency and folds products into a 4x4 accumulator.
module etc_tile_sched #(
  parameter int W  = 16,
  parameter int KW = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [1:0]                start_op,
  input  logic [KW-1:0]             start_k,
  input  logic                      tile_valid,
  output logic                      tile_ready,
  input  logic [3:0][3:0][W-1:0]    tile_a,
  input  logic [3:0][3:0][W-1:0]    tile_b,
  output logic [1:0]                etc_op,
  output logic [3:0][3:0][W-1:0]    etc_in_a,
  output logic [3:0][3:0][W-1:0]    etc_in_b,
  input  logic [3:0][3:0][W-1:0]    etc_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [3:0][3:0][W-1:0]    res_data,
  output logic                      busy,
  output logic [1:0]                o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends on valid, and the producer holds data stable while valid && !ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [1:0]               r_op;
  logic [KW-1:0]            r_k;
  logic [KW-1:0]            r_issued;
  logic [KW-1:0]            r_returned;
  logic [1:0]               r_vpipe;
  logic [3:0][3:0][W-1:0]   r_acc;

  logic                     w_start_hs;
  logic                     w_tile_hs;
  logic                     w_res_hs;
  logic                     w_capture;
  logic [KW-1:0]            w_returned_inc;
  logic [3:0][3:0][W-1:0]   w_acc_next;

  assign start_ready    = (r_state == S_IDLE);
  assign tile_ready     = (r_state == S_RUN) && (r_issued < r_k);
  assign res_valid      = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);
  assign etc_op         = r_op;
  assign etc_in_a       = tile_a;
  assign etc_in_b       = tile_b;
  assign res_data       = r_acc;
  assign o_dbg_state    = r_state;

  assign w_start_hs     = start_valid && start_ready;
  assign w_tile_hs      = tile_valid && tile_ready;
  assign w_res_hs       = res_valid && res_ready;
  // vpipe[1] marks the cycle in which the core output belongs to an accepted tile.
  assign w_capture      = r_vpipe[1] && (r_state == S_RUN);
  assign w_returned_inc = r_returned + 1'b1;

  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (r_returned == '0) begin
          w_acc_next[i][j] = etc_out[i][j];
        end else if (r_op == 2'd0) begin
          w_acc_next[i][j] = r_acc[i][j] + etc_out[i][j];
        end else begin
          w_acc_next[i][j] = (etc_out[i][j] > r_acc[i][j]) ? etc_out[i][j] : r_acc[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_k        <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_vpipe    <= '0;
      r_acc      <= '0;
    end else begin
      r_vpipe <= {r_vpipe[0], w_tile_hs};
      case (r_state)
        S_IDLE: begin
          if (w_start_hs) begin
            r_op       <= start_op;
            r_k        <= start_k;
            r_issued   <= '0;
            r_returned <= '0;
            r_acc      <= '0;
            r_state    <= (start_k == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_tile_hs) begin
            r_issued <= r_issued + 1'b1;
          end
          if (w_capture) begin
            r_acc      <= w_acc_next;
            r_returned <= w_returned_inc;
            if (w_returned_inc == r_k) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_res_hs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_etc_tile_sched.sv
// Directed bench for etc_tile_sched with a two-stage core model and a result scoreboard.
module tb_etc_tile_sched;

  localparam int W  = 16;
  localparam int KW = 4;
  typedef logic [3:0][3:0][W-1:0] mat_t;

  logic               clk;
  logic               rst_n;
  logic               start_valid;
  logic               start_ready;
  logic [1:0]         start_op;
  logic [KW-1:0]      start_k;
  logic               tile_valid;
  logic               tile_ready;
  mat_t               tile_a;
  mat_t               tile_b;
  logic [1:0]         etc_op;
  mat_t               etc_in_a;
  mat_t               etc_in_b;
  mat_t               etc_out;
  logic               res_valid;
  logic               res_ready;
  mat_t               res_data;
  logic               busy;
  logic [1:0]         dbg_state;

  int                 n_vec;
  int                 n_fail;
  logic [16*W-1:0]    exp_q[$];
  mat_t               ta[0:15];
  mat_t               tbm[0:15];
  mat_t               core_s1;
  mat_t               core_s2;

  etc_tile_sched #(.W(W), .KW(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_op    (start_op),
    .start_k     (start_k),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .tile_a      (tile_a),
    .tile_b      (tile_b),
    .etc_op      (etc_op),
    .etc_in_a    (etc_in_a),
    .etc_in_b    (etc_in_b),
    .etc_out     (etc_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Semiring product of two 4x4 tiles: sum-of-products or max-plus, modulo 2^W.
  function automatic mat_t core_fn(input logic [1:0] op, input mat_t a, input mat_t b);
    mat_t r;
    logic [W-1:0] s;
    logic [W-1:0] t;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int kk = 0; kk < 4; kk++) begin
          if (op == 2'd0) begin
            t = a[i][kk] * b[kk][j];
            s = s + t;
          end else begin
            t = a[i][kk] + b[kk][j];
            s = (kk == 0 || t > s) ? t : s;
          end
        end
        r[i][j] = s;
      end
    end
    return r;
  endfunction

  function automatic mat_t fill(input logic [W-1:0] v);
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = v;
    return r;
  endfunction

  function automatic mat_t ident();
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = (i == j) ? W'(1) : W'(0);
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = W'($urandom);
    return r;
  endfunction

  // External core: registered result two edges after its operands are presented.
  always @(posedge clk) begin
    core_s1 <= core_fn(etc_op, etc_in_a, etc_in_b);
    core_s2 <= core_s1;
  end
  assign etc_out = core_s2;

  task automatic chk(input string tag, input logic [16*W-1:0] obs, input logic [16*W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one job, tiles ta/tbm[0..k-1] back-to-back, result held for 'hold' cycles
  task automatic run_job(input logic [1:0] op, input int k, input int hold, input string tag);
    mat_t p;
    mat_t e;
    logic [16*W-1:0] exp_v;
    int lat;
    e = '0;
    for (int i = 0; i < k; i++) begin
      p = core_fn(op, ta[i], tbm[i]);
      if (i == 0) e = p;
      else begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (op == 2'd0) e[r][c] = e[r][c] + p[r][c];
            else e[r][c] = (p[r][c] > e[r][c]) ? p[r][c] : e[r][c];
      end
    end
    exp_q.push_back(e);

    @(negedge clk);
    start_valid = 1'b1;
    start_op    = op;
    start_k     = KW'(k);
    chk({tag, ".start_ready"}, start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    for (int i = 0; i < k; i++) begin
      tile_valid = 1'b1;
      tile_a     = ta[i];
      tile_b     = tbm[i];
      chk({tag, ".tile_ready"}, tile_ready, 1);
      @(negedge clk);
    end
    tile_valid = 1'b0;
    tile_a     = rand_mat();
    tile_b     = rand_mat();
    chk({tag, ".tile_ready_off"}, tile_ready, 0);

    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, (k == 0) ? 1 : 3);
    chk({tag, ".res_valid"}, res_valid, 1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk({tag, ".res_data"}, res_data, exp_v);
    end else begin
      exp_v = '0;
      chk({tag, ".queue_empty"}, 1, 0);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, res_valid, 1);
      chk({tag, ".hold_data"}, res_data, exp_v);
      chk({tag, ".hold_start_ready"}, start_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, ".post_res_valid"}, res_valid, 0);
    chk({tag, ".post_start_ready"}, start_ready, 1);
    chk({tag, ".post_busy"}, busy, 0);
  endtask

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    start_op    = '0;
    start_k     = '0;
    tile_valid  = 1'b0;
    tile_a      = '0;
    tile_b      = '0;
    res_ready   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.start_ready", start_ready, 1);
    chk("rst.tile_ready", tile_ready, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.etc_op", etc_op, 0);
    chk("rst.res_data", res_data, 0);
    chk("rst.state", dbg_state, 0);
    rst_n = 1'b1;

    // identity x all-3
    ta[0] = ident(); tbm[0] = fill(16'd3);
    run_job(2'd0, 1, 0, "k1_ident");

    // two back-to-back all-1 tiles
    ta[0] = fill(16'd1); tbm[0] = fill(16'd1);
    ta[1] = fill(16'd1); tbm[1] = fill(16'd1);
    run_job(2'd0, 2, 0, "k2_ones");

    // max-plus
    ta[0] = fill(16'd2); tbm[0] = fill(16'd3);
    ta[1] = fill(16'd4); tbm[1] = fill(16'd5);
    run_job(2'd1, 2, 0, "maxplus");

    // wraparound with result backpressure
    ta[0] = fill(16'h0100); tbm[0] = fill(16'h0100);
    run_job(2'd0, 1, 5, "wrap_hold");

    run_job(2'd0, 0, 0, "k0");

    // reset one cycle after the first of three tiles is accepted
    @(negedge clk);
    start_valid = 1'b1;
    start_op    = 2'd1;
    start_k     = KW'(3);
    @(negedge clk);
    start_valid = 1'b0;
    tile_valid  = 1'b1;
    tile_a      = fill(16'd7);
    tile_b      = fill(16'd9);
    @(negedge clk);
    tile_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("midrst.start_ready", start_ready, 1);
    chk("midrst.tile_ready", tile_ready, 0);
    chk("midrst.res_valid", res_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.etc_op", etc_op, 0);
    chk("midrst.res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst.no_res_valid", res_valid, 0);
      chk("midrst.idle", busy, 0);
    end

    ta[0] = fill(16'd6); tbm[0] = ident();
    run_job(2'd0, 1, 0, "after_rst");

    for (int n = 0; n < 4; n++) begin
      int k;
      logic [1:0] op;
      k  = $urandom_range(1, 5);
      op = 2'($urandom_range(0, 3));
      for (int i = 0; i < k; i++) begin
        ta[i]  = rand_mat();
        tbm[i] = rand_mat();
      end
      run_job(op, k, $urandom_range(0, 2), "random");
    end

    chk("scoreboard.drained", exp_q.size(), 0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/etc_tile_sched.md
ETC_TILE_SCHED -- requirements
Module: etc_tile_sched

Interface
- REQ-001 SHALL have parameter W, default 16, the element width matching the extended tensor core datapath.
- REQ-002 SHALL have parameter KW, default 4, the width of the K-tile count.
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
- REQ-005 SHALL have port start_valid  input  1  job request.
- REQ-006 SHALL have port start_ready  output  1  job accepted when high with start_valid.
- REQ-007 SHALL have port start_op  input  2  semiring select; 0 = multiply-add, nonzero = max-plus.
- REQ-008 SHALL have port start_k  input  KW  number of A/B tile pairs in the job.
- REQ-009 SHALL have port tile_valid, tile_ready  input/output  1 each  operand tile handshake.
- REQ-010 SHALL have port tile_a, tile_b  input  [3:0][3:0][W-1:0] each  operand tiles.
- REQ-011 SHALL have port etc_op  output  2  drives core op.
- REQ-012 SHALL have port etc_in_a, etc_in_b  output  [3:0][3:0][W-1:0] each  drive core inA/inB.
- REQ-013 SHALL have port etc_out  input  [3:0][3:0][W-1:0]  core registered result.
- REQ-014 SHALL have port res_valid, res_ready  output/input  1 each  result handshake.
- REQ-015 SHALL have port res_data  output  [3:0][3:0][W-1:0]  accumulated 4x4 result.
- REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
- REQ-017 SHALL implement states IDLE, RUN, DONE.
- REQ-018 SHALL drive start_ready = (state==IDLE); a start handshake latches op and k and clears acc, issue count and return count.
- REQ-019 SHALL go to RUN after a handshake with k>0, and to DONE with acc = all zero when k==0.
- REQ-020 SHALL drive tile_ready = (state==RUN) && (issued < k); each tile handshake increments issued.
- REQ-021 SHALL pass tile_a/tile_b combinationally to etc_in_a/etc_in_b, and hold etc_op at the latched op from the start handshake until the job returns to IDLE.
- REQ-022 SHALL track core latency with a 2-stage valid pipe: a tile accepted at edge t has its product on etc_out captured at edge t+2; non-handshake cycles insert bubbles.
- REQ-023 SHALL, on capture with returned==0, load acc = etc_out.
- REQ-024 SHALL, on later captures, set acc = acc + etc_out elementwise modulo 2^W when op==0, else the elementwise unsigned maximum.
- REQ-025 SHALL increment returned on each capture and go RUN->DONE on the same edge that the k-th capture completes.
- REQ-026 SHALL accept one tile per cycle, back-to-back, with no stall between tiles.
- REQ-027 SHALL hold res_valid=1 and res_data=acc stable in DONE, and go to IDLE on res_valid && res_ready.
- REQ-028 SHALL ignore start_valid while not in IDLE; a start and a result handshake in the same cycle are not possible.
- REQ-029 SHALL keep res_data = acc at all times.

Reset
- REQ-030 SHALL, on rst_n low, immediately return to IDLE and clear the following: acc, counters, valid pipe, latched op.
- REQ-031 SHALL hold outputs during reset at: start_ready=1, tile_ready=0, res_valid=0, busy=0, etc_op=0, res_data=0.
- REQ-032 SHALL discard any in-flight core result when reset is asserted mid-job; it SHALL NOT be captured after reset release.

Verification
- REQ-033 SHALL pass: op=0, k=1, A=identity, B=all 3, tile accepted at edge t -> res_valid high after edge t+2, res_data all 3.
- REQ-034 SHALL pass: op=0, k=2, back-to-back tiles A=B=all 1 -> tile_ready high 2 consecutive cycles, res_data all 8.
- REQ-035 SHALL pass: op=1, k=2, tiles (A all 2, B all 3) then (A all 4, B all 5) -> res_data all 9.
- REQ-036 SHALL pass: op=0, k=1, A=B=all 0x0100 -> res_data all 0 (wrap); then res_ready held low 5 cycles -> res_valid and res_data stable, start_ready 0.
- REQ-037 SHALL pass: start with k=0 -> res_valid the next cycle, res_data all 0.
- REQ-038 SHALL pass: rst_n pulsed low one cycle after the 1st of 3 tiles is accepted -> IDLE, busy 0, no later res_valid; a new job with k=1 completes correctly.
